// File: rtl/sram_access_controller.sv
// Arbitrates strobed write channels and one read channel onto an async SRAM; writes take 3+WE_CYCLES clocks, reads READ_CYCLES+1 after grant.
// Requests are single-entry per channel: a strobe while that channel is pending is dropped (OVERRUN for writes).
module sram_access_controller #(
    parameter int ADDR_WIDTH  = 19,
    parameter int DATA_WIDTH  = 8,
    parameter int N_WR_PORTS  = 2,
    parameter int WE_CYCLES   = 1,
    parameter int READ_CYCLES = 2,
    parameter int WRAP_EN     = 0
) (
    input  logic                             CLK_MASTER,
    input  logic                             RESET,
    input  logic [N_WR_PORTS-1:0]            WR_STB,
    input  logic [N_WR_PORTS*DATA_WIDTH-1:0] WR_DATA,
    output logic [N_WR_PORTS-1:0]            WR_ACK,
    output logic [N_WR_PORTS-1:0]            OVERRUN,
    input  logic                             RD_STB,
    output logic [DATA_WIDTH-1:0]            RD_DATA,
    output logic                             RD_VALID,
    input  logic                             ADDR_LOAD,
    input  logic [ADDR_WIDTH-1:0]            ADDR_LOAD_VAL,
    output logic                             EMPTY,
    output logic                             FULL,
    output logic                             BUSY,
    output logic [ADDR_WIDTH-1:0]            SRAM_A,
    output logic [DATA_WIDTH-1:0]            SRAM_DQ_OUT,
    output logic                             SRAM_DQ_OE,
    input  logic [DATA_WIDTH-1:0]            SRAM_DQ_IN,
    output logic                             SRAM_WE_n,
    output logic                             SRAM_OE_n
);
    localparam int GW   = (N_WR_PORTS > 1) ? $clog2(N_WR_PORTS) : 1;
    localparam int CMAX = (WE_CYCLES > READ_CYCLES) ? WE_CYCLES : READ_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_OEIA, S_WRITE, S_WREND, S_INCADDR, S_READ, S_RDCAP
    } state_t;

    state_t                                 state_q, state_d;
    logic [N_WR_PORTS-1:0][DATA_WIDTH-1:0]  hold_q, hold_d;
    logic [N_WR_PORTS-1:0]                  pend_q, pend_d;
    logic [N_WR_PORTS-1:0]                  ovr_q, ovr_d;
    logic [N_WR_PORTS-1:0]                  wr_ack_q, wr_ack_d;
    logic                                   pend_rd_q, pend_rd_d;
    logic [GW-1:0]                          gnt_q, gnt_d;
    logic [CW-1:0]                          cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]                  addr_q, addr_d;
    logic                                   full_q, full_d;
    logic                                   ld_pend_q, ld_pend_d;
    logic [ADDR_WIDTH-1:0]                  ld_val_q, ld_val_d;
    logic [DATA_WIDTH-1:0]                  dq_q, dq_d;
    logic [DATA_WIDTH-1:0]                  rd_data_q, rd_data_d;
    logic                                   rd_vld_q, rd_vld_d;

    logic                                   wr_found;
    logic [GW-1:0]                          wr_sel;
    logic [ADDR_WIDTH-1:0]                  adv_addr, ld_eff;
    logic                                   adv_full, ld_any;

    always_comb begin
        wr_found = 1'b0;
        wr_sel   = '0;
        for (int i = N_WR_PORTS - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                wr_found = 1'b1;
                wr_sel   = GW'(i);
            end
        end
    end

    // Counter stops at max without wrap; the read/write that lands there raises FULL.
    always_comb begin
        adv_full = (WRAP_EN == 0) && (addr_q == ADDR_MAX);
        adv_addr = adv_full ? addr_q : addr_q + 1'b1;
        ld_any   = ADDR_LOAD | ld_pend_q;
        ld_eff   = ADDR_LOAD ? ADDR_LOAD_VAL : ld_val_q;
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        pend_d    = pend_q;
        ovr_d     = ovr_q;
        wr_ack_d  = '0;
        pend_rd_d = pend_rd_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        full_d    = full_q;
        ld_pend_d = ld_pend_q;
        ld_val_d  = ld_val_q;
        dq_d      = dq_q;
        rd_data_d = rd_data_q;
        rd_vld_d  = 1'b0;

        for (int i = 0; i < N_WR_PORTS; i++) begin
            if (WR_STB[i]) begin
                if (pend_q[i]) begin
                    ovr_d[i] = 1'b1;
                end else begin
                    hold_d[i] = WR_DATA[i*DATA_WIDTH +: DATA_WIDTH];
                    pend_d[i] = 1'b1;
                end
            end
        end
        if (RD_STB && !pend_rd_q) pend_rd_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                // A pending or fresh load takes this slot so the next grant sees the new address.
                if (ld_any) begin
                    addr_d    = ld_eff;
                    full_d    = 1'b0;
                    ld_pend_d = 1'b0;
                end else if (wr_found) begin
                    if (full_q) begin
                        pend_d[wr_sel] = 1'b0;
                        ovr_d[wr_sel]  = 1'b1;
                    end else begin
                        gnt_d   = wr_sel;
                        dq_d    = hold_q[wr_sel];
                        state_d = S_OEIA;
                    end
                end else if (pend_rd_q) begin
                    cnt_d   = CW'(READ_CYCLES - 1);
                    state_d = S_READ;
                end
            end
            S_OEIA: begin
                cnt_d   = CW'(WE_CYCLES - 1);
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (cnt_q == '0) state_d = S_WREND;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_WREND:   state_d = S_INCADDR;
            S_INCADDR: begin
                wr_ack_d[gnt_q] = 1'b1;
                pend_d[gnt_q]   = 1'b0;
                addr_d          = adv_addr;
                if (adv_full) full_d = 1'b1;
                state_d = S_IDLE;
            end
            S_READ: begin
                if (cnt_q == '0) state_d = S_RDCAP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_RDCAP: begin
                rd_data_d = SRAM_DQ_IN;
                rd_vld_d  = 1'b1;
                pend_rd_d = 1'b0;
                addr_d    = adv_addr;
                if (adv_full) full_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE) begin
            if (ADDR_LOAD) begin
                ld_pend_d = 1'b1;
                ld_val_d  = ADDR_LOAD_VAL;
            end
            // Stored load lands on the return edge and wins over the advance.
            if (state_d == S_IDLE && ld_any) begin
                addr_d    = ld_eff;
                full_d    = 1'b0;
                ld_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK_MASTER or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            hold_q    <= '0;
            pend_q    <= '0;
            ovr_q     <= '0;
            wr_ack_q  <= '0;
            pend_rd_q <= 1'b0;
            gnt_q     <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            full_q    <= 1'b0;
            ld_pend_q <= 1'b0;
            ld_val_q  <= '0;
            dq_q      <= '0;
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            pend_q    <= pend_d;
            ovr_q     <= ovr_d;
            wr_ack_q  <= wr_ack_d;
            pend_rd_q <= pend_rd_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            full_q    <= full_d;
            ld_pend_q <= ld_pend_d;
            ld_val_q  <= ld_val_d;
            dq_q      <= dq_d;
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
        end
    end

    // Pin strobes decode straight from the state register so reset forces them at once.
    assign SRAM_WE_n   = (state_q != S_WRITE);
    assign SRAM_OE_n   = !(state_q == S_IDLE || state_q == S_READ || state_q == S_RDCAP);
    assign SRAM_DQ_OE  = (state_q == S_OEIA || state_q == S_WRITE || state_q == S_WREND);
    assign SRAM_DQ_OUT = dq_q;
    assign SRAM_A      = addr_q;
    assign WR_ACK      = wr_ack_q;
    assign OVERRUN     = ovr_q;
    assign RD_DATA     = rd_data_q;
    assign RD_VALID    = rd_vld_q;
    assign EMPTY       = (addr_q == '0);
    assign FULL        = full_q;
    assign BUSY        = (state_q != S_IDLE) || (|pend_q) || pend_rd_q;
endmodule

// File: tb/tb_sram_access_controller.sv
// Directed bench for sram_access_controller: expected SRAM writes, acks and read data are
// queued at stimulus time and popped by a negedge monitor; a second instance covers wrap mode.
module tb_sram_access_controller;
    localparam int AW = 19;
    localparam int DW = 8;
    localparam int N  = 2;
    localparam logic [AW-1:0] MAX = '1;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    wr_stb;
    logic [N*DW-1:0] wr_data;
    logic            rd_stb, addr_load;
    logic [AW-1:0]   addr_load_val;
    logic [DW-1:0]   dq_in;
    logic [N-1:0]    wr_ack, overrun;
    logic [DW-1:0]   rd_data, dq_out;
    logic            rd_valid, empty, full, busy, dq_oe, we_n, oe_n;
    logic [AW-1:0]   sram_a;

    logic [N-1:0]    w_stb;
    logic [N*DW-1:0] w_data;
    logic            w_rd, w_load;
    logic [AW-1:0]   w_load_val;
    logic [N-1:0]    w_ack, w_ovr;
    logic [DW-1:0]   w_rd_data, w_dq_out;
    logic            w_rd_valid, w_empty, w_full, w_busy, w_dq_oe, w_we_n, w_oe_n;
    logic [AW-1:0]   w_sram_a;

    sram_access_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_WR_PORTS(N),
        .WE_CYCLES(1), .READ_CYCLES(2), .WRAP_EN(0)) u_dut (
        .CLK_MASTER(clk), .RESET(rst), .WR_STB(wr_stb), .WR_DATA(wr_data),
        .WR_ACK(wr_ack), .OVERRUN(overrun), .RD_STB(rd_stb), .RD_DATA(rd_data),
        .RD_VALID(rd_valid), .ADDR_LOAD(addr_load), .ADDR_LOAD_VAL(addr_load_val),
        .EMPTY(empty), .FULL(full), .BUSY(busy), .SRAM_A(sram_a), .SRAM_DQ_OUT(dq_out),
        .SRAM_DQ_OE(dq_oe), .SRAM_DQ_IN(dq_in), .SRAM_WE_n(we_n), .SRAM_OE_n(oe_n));

    sram_access_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_WR_PORTS(N),
        .WE_CYCLES(1), .READ_CYCLES(2), .WRAP_EN(1)) u_wrap (
        .CLK_MASTER(clk), .RESET(rst), .WR_STB(w_stb), .WR_DATA(w_data),
        .WR_ACK(w_ack), .OVERRUN(w_ovr), .RD_STB(w_rd), .RD_DATA(w_rd_data),
        .RD_VALID(w_rd_valid), .ADDR_LOAD(w_load), .ADDR_LOAD_VAL(w_load_val),
        .EMPTY(w_empty), .FULL(w_full), .BUSY(w_busy), .SRAM_A(w_sram_a), .SRAM_DQ_OUT(w_dq_out),
        .SRAM_DQ_OE(w_dq_oe), .SRAM_DQ_IN(dq_in), .SRAM_WE_n(w_we_n), .SRAM_OE_n(w_oe_n));

    int tests  = 0;
    int errors = 0;
    wexp_t         wr_q[$];
    int            ack_q[$];
    logic [DW-1:0] rd_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] v);
        addr_load     = 1'b1;
        addr_load_val = v;
        step();
        addr_load     = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (busy === 1'b1 && n < 40);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    // Scoreboard: every SRAM write, ack pulse and read capture must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (we_n === 1'b0) begin
                chk("we_while_oe", {31'd0, oe_n}, 32'd1);
                chk("wr_expected", {31'd0, wr_q.size() != 0}, 32'd1);
                if (wr_q.size() != 0) begin
                    wexp_t e;
                    e = wr_q.pop_front();
                    chk("wr_addr", {13'd0, sram_a}, {13'd0, e.a});
                    chk("wr_data", {24'd0, dq_out}, {24'd0, e.d});
                end
            end
            for (int c = 0; c < N; c++) begin
                if (wr_ack[c] === 1'b1) begin
                    chk("ack_expected", {31'd0, ack_q.size() != 0}, 32'd1);
                    if (ack_q.size() != 0) chk("ack_chan", c, ack_q.pop_front());
                end
            end
            if (rd_valid === 1'b1) begin
                chk("rd_expected", {31'd0, rd_q.size() != 0}, 32'd1);
                if (rd_q.size() != 0) chk("rd_data", {24'd0, rd_data}, {24'd0, rd_q.pop_front()});
            end
        end
    end

    initial begin
        int acks;
        int n;
        wr_stb = '0; wr_data = '0; rd_stb = 1'b0; addr_load = 1'b0; addr_load_val = '0;
        dq_in = '0; w_stb = '0; w_data = '0; w_rd = 1'b0; w_load = 1'b0; w_load_val = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we_n", {31'd0, we_n}, 32'd1);
        chk("rst_oe_n", {31'd0, oe_n}, 32'd0);
        chk("rst_dq_oe", {31'd0, dq_oe}, 32'd0);
        chk("rst_addr", {13'd0, sram_a}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
        chk("rst_dq_out", {24'd0, dq_out}, 32'd0);
        chk("rst_ovr", {30'd0, overrun}, 32'd0);
        rst = 1'b0;
        step();

        // Single write on channel 0, cycle by cycle.
        load(19'h10);
        chk("load_addr", {13'd0, sram_a}, 32'h10);
        wr_q.push_back('{19'h10, 8'hA5});
        ack_q.push_back(0);
        wr_stb = 2'b01; wr_data = 16'h00A5;
        step();
        wr_stb = 2'b00;
        chk("t2_busy", {31'd0, busy}, 32'd1);
        chk("t2_oe_idle", {31'd0, oe_n}, 32'd0);
        step();
        chk("t2_oeia_oe_n", {31'd0, oe_n}, 32'd1);
        chk("t2_oeia_dq_oe", {31'd0, dq_oe}, 32'd1);
        chk("t2_oeia_we_n", {31'd0, we_n}, 32'd1);
        chk("t2_dq_out", {24'd0, dq_out}, 32'hA5);
        step();
        chk("t2_write_we_n", {31'd0, we_n}, 32'd0);
        step();
        chk("t2_wrend_we_n", {31'd0, we_n}, 32'd1);
        chk("t2_wrend_dq_oe", {31'd0, dq_oe}, 32'd1);
        step();
        chk("t2_inc_dq_oe", {31'd0, dq_oe}, 32'd0);
        chk("t2_inc_ack", {30'd0, wr_ack}, 32'd0);
        step();
        chk("t2_ack", {30'd0, wr_ack}, 32'd1);
        chk("t2_addr", {13'd0, sram_a}, 32'h11);

        // Simultaneous strobes: channel 0 first.
        wr_q.push_back('{19'h11, 8'h11});
        wr_q.push_back('{19'h12, 8'h22});
        ack_q.push_back(0);
        ack_q.push_back(1);
        wr_stb = 2'b11; wr_data = 16'h2211;
        step();
        wr_stb = 2'b00;
        wait_idle("t3");
        chk("t3_addr", {13'd0, sram_a}, 32'h13);
        chk("t3_ovr", {30'd0, overrun}, 32'd0);

        // Read with two-cycle access.
        dq_in = 8'h3C;
        rd_q.push_back(8'h3C);
        rd_stb = 1'b1;
        step();
        rd_stb = 1'b0;
        step();
        chk("t4_read_oe_n", {31'd0, oe_n}, 32'd0);
        chk("t4_early_valid", {31'd0, rd_valid}, 32'd0);
        step();
        step();
        chk("t4_rdcap_valid", {31'd0, rd_valid}, 32'd0);
        step();
        chk("t4_valid", {31'd0, rd_valid}, 32'd1);
        chk("t4_rd_data", {24'd0, rd_data}, 32'h3C);
        chk("t4_addr", {13'd0, sram_a}, 32'h14);
        step();
        chk("t4_valid_pulse", {31'd0, rd_valid}, 32'd0);
        chk("t4_rd_hold", {24'd0, rd_data}, 32'h3C);

        // Overrun on channel 0, then a load while the write is in flight.
        wr_q.push_back('{19'h14, 8'h5A});
        ack_q.push_back(0);
        wr_q.push_back('{19'h100, 8'h77});
        ack_q.push_back(1);
        wr_stb = 2'b01; wr_data = 16'h005A;
        step();
        wr_data = 16'h0066;
        step();
        wr_stb = 2'b00;
        chk("t6_ovr", {30'd0, overrun}, 32'd1);
        chk("t6_dq_first", {24'd0, dq_out}, 32'h5A);
        addr_load = 1'b1; addr_load_val = 19'h100;
        wr_stb = 2'b10; wr_data = 16'h7766;
        step();
        addr_load = 1'b0; wr_stb = 2'b00;
        chk("t6_old_addr", {13'd0, sram_a}, 32'h14);
        wait_idle("t6");
        chk("t6_addr", {13'd0, sram_a}, 32'h101);
        chk("t6_ovr_sticky", {30'd0, overrun}, 32'd1);

        // Stop-at-max: first write fills, second is dropped, read still runs.
        load(MAX);
        chk("t5_full_clr", {31'd0, full}, 32'd0);
        wr_q.push_back('{MAX, 8'h01});
        ack_q.push_back(1);
        wr_stb = 2'b10; wr_data = 16'h0100;
        step();
        wr_stb = 2'b00;
        wait_idle("t5_w1");
        chk("t5_full", {31'd0, full}, 32'd1);
        chk("t5_addr_max", {13'd0, sram_a}, {13'd0, MAX});
        chk("t5_not_empty", {31'd0, empty}, 32'd0);
        wr_stb = 2'b10; wr_data = 16'h0200;
        step();
        wr_stb = 2'b00;
        wait_idle("t5_w2");
        chk("t5_ovr", {30'd0, overrun}, 32'd3);
        chk("t5_full_hold", {31'd0, full}, 32'd1);
        dq_in = 8'hC3;
        rd_q.push_back(8'hC3);
        rd_stb = 1'b1;
        step();
        rd_stb = 1'b0;
        wait_idle("t5_rd");
        step();
        chk("t5_rd_data", {24'd0, rd_data}, 32'hC3);
        chk("t5_rd_addr", {13'd0, sram_a}, {13'd0, MAX});
        chk("t5_rd_full", {31'd0, full}, 32'd1);
        load('0);
        chk("t5_load_full", {31'd0, full}, 32'd0);
        chk("t5_load_empty", {31'd0, empty}, 32'd1);

        // Wrapping instance: write at max rolls to zero.
        w_load = 1'b1; w_load_val = MAX;
        step();
        w_load = 1'b0;
        chk("wrap_load", {13'd0, w_sram_a}, {13'd0, MAX});
        w_stb = 2'b01; w_data = 16'h0099;
        step();
        w_stb = 2'b00;
        acks = 0;
        n = 0;
        do begin
            step();
            n++;
            if (w_ack[0] === 1'b1) acks++;
        end while (w_busy === 1'b1 && n < 40);
        chk("wrap_idle", {31'd0, w_busy}, 32'd0);
        chk("wrap_acks", acks, 32'd1);
        chk("wrap_addr", {13'd0, w_sram_a}, 32'd0);
        chk("wrap_empty", {31'd0, w_empty}, 32'd1);
        chk("wrap_full", {31'd0, w_full}, 32'd0);

        // Reset in the middle of a write strobe.
        load(19'h55);
        wr_stb = 2'b01; wr_data = 16'h00EE;
        step();
        wr_stb = 2'b00;
        step();
        step();
        chk("t1_in_write", {31'd0, we_n}, 32'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("t1_we_n", {31'd0, we_n}, 32'd1);
        chk("t1_dq_oe", {31'd0, dq_oe}, 32'd0);
        chk("t1_addr", {13'd0, sram_a}, 32'd0);
        chk("t1_empty", {31'd0, empty}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_ovr", {30'd0, overrun}, 32'd0);

        chk("wr_q_drained", wr_q.size(), 32'd0);
        chk("ack_q_drained", ack_q.size(), 32'd0);
        chk("rd_q_drained", rd_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
